// File: rtl/ml_param_ram.sv
// ml_param_ram
// Parameter RAM with one write port and one registered read port.
// Its contents can be zeroed by a hardware sweep that writes one word per
// cycle. The sweep runs after every reset and after every clr request. This
// means the storage array never needs an asynchronous reset.
//
// Ports
//   CLOCK_50 : sole clock; all state changes on the rising edge
//   rst_n    : asynchronous active-low reset; after release a full sweep runs
//   clr      : single-cycle request to zero every word (ignored while busy)
//   we       : write enable
//   waddr    : write address
//   din      : write data
//   re       : read request
//   raddr    : read address
//   dout     : registered read data; holds its value when rvalid is low
//   rvalid   : one-cycle strobe for each accepted read
//   busy     : clear sweep in progress
//   werr     : sticky flag, set when a write was dropped (busy, clr or out of range)
module ml_param_ram #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              rvalid,
    output logic              busy,
    output logic              werr
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // The extra bit lets DEPTH == 2**ADDR_W be compared without overflow.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] sweep_cnt;

    logic              sweep_last;
    logic              waddr_ok;
    logic              raddr_ok;
    logic              wr_accept;
    logic              wr_drop;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_cleared;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the control terms shared by the write and read paths.
    // A write in the same cycle as clr is dropped, so clr takes priority.
    always_comb begin
        state_next = state;
        waddr_ok   = ({1'b0, waddr} < DEPTH_EXT);
        raddr_ok   = ({1'b0, raddr} < DEPTH_EXT);
        sweep_last = (state == CLEAR) && (sweep_cnt == LAST_WORD);
        wr_accept  = (state == IDLE) && we && !clr && waddr_ok;
        wr_drop    = we && !wr_accept;

        case (state)
            IDLE:    if (clr)        state_next = CLEAR;
            CLEAR:   if (sweep_last) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // The sweep counter wraps to 0 on its last word. This keeps it from ever
    // addressing past DEPTH-1, and the next sweep then starts at word 0.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt <= '0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
        end else begin
            sweep_cnt <= '0;
        end
    end

    // Only one source writes the array: the sweep while clearing, or a
    // user write while idle. Writes are blocked while reset is held, so
    // inputs applied during reset cannot disturb the contents.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = din;
        if (state == CLEAR) begin
            mem_we    = rst_n;
            mem_waddr = sweep_cnt;
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we = rst_n;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Reads are read-first. During a sweep, any word at or below the sweep
    // pointer reads as zero, even if the sweep clears it on this same edge.
    always_comb begin
        rd_cleared = (state == CLEAR) && (raddr <= sweep_cnt);
        rd_data    = '0;
        if (raddr_ok && !rd_cleared) begin
            rd_data = mem[raddr];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            rvalid <= 1'b0;
            werr   <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                dout <= rd_data;
            end
            if (wr_drop) begin
                werr <= 1'b1;
            end
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_ml_param_ram.sv
// tb_ml_param_ram
// Drives one stimulus stream into two ml_param_ram instances: the default
// DEPTH=16 and a DEPTH=10 variant. Each instance has its own reference model.
// The stimulus process updates the models and queues the expected read data.
// A monitor on the falling edge pops the queues and compares the DUT outputs.
module tb_ml_param_ram;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       we;
    logic [3:0] waddr;
    logic [3:0] din;
    logic       re;
    logic [3:0] raddr;

    logic [3:0] dout_a, dout_b;
    logic       rvalid_a, rvalid_b;
    logic       busy_a, busy_b;
    logic       werr_a, werr_b;

    always #5 CLOCK_50 = ~CLOCK_50;

    ml_param_ram #(.DATA_W(4), .DEPTH(16), .ADDR_W(4)) dut_a (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr),
        .din(din), .re(re), .raddr(raddr), .dout(dout_a), .rvalid(rvalid_a),
        .busy(busy_a), .werr(werr_a)
    );

    ml_param_ram #(.DATA_W(4), .DEPTH(10), .ADDR_W(4)) dut_b (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr),
        .din(din), .re(re), .raddr(raddr), .dout(dout_b), .rvalid(rvalid_b),
        .busy(busy_b), .werr(werr_b)
    );

    // Reference model. sweep_pos is -1 when idle. Otherwise it is the next
    // word to be zeroed, and every word below it already reads as zero.
    int         depth [2] = '{16, 10};
    logic [3:0] ref_mem [2][16];
    int         sweep_pos [2];
    bit         ref_werr [2];
    bit         ref_rvalid [2];
    logic [3:0] ref_dout [2];
    logic [3:0] expq_a [$];
    logic [3:0] expq_b [$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sweep_pos[k]  = 0;
            ref_werr[k]   = 1'b0;
            ref_rvalid[k] = 1'b0;
            ref_dout[k]   = 4'h0;
        end
        expq_a.delete();
        expq_b.delete();
    endtask

    // Applies the effects of the coming rising edge to model k, given the
    // inputs that are currently driven.
    task automatic model_step(input int k);
        bit         is_busy;
        logic [3:0] exp_rd;
        is_busy = (sweep_pos[k] >= 0);
        ref_rvalid[k] = re;
        if (re) begin
            if (int'(raddr) >= depth[k])                     exp_rd = 4'h0;
            else if (is_busy && int'(raddr) <= sweep_pos[k]) exp_rd = 4'h0;
            else                                             exp_rd = ref_mem[k][raddr];
            if (k == 0) expq_a.push_back(exp_rd);
            else        expq_b.push_back(exp_rd);
        end
        if (we) begin
            if (!is_busy && !clr && int'(waddr) < depth[k]) ref_mem[k][waddr] = din;
            else                                            ref_werr[k] = 1'b1;
        end
        if (is_busy) begin
            ref_mem[k][sweep_pos[k]] = 4'h0;
            sweep_pos[k]++;
            if (sweep_pos[k] == depth[k]) sweep_pos[k] = -1;
        end else if (clr) begin
            sweep_pos[k] = 0;
        end
    endtask

    task automatic applyStimulus(input bit r_n, input bit c, input bit w, input logic [3:0] wa,
                                 input logic [3:0] d, input bit rd, input logic [3:0] ra);
        @(negedge CLOCK_50);
        #1;
        rst_n = r_n;
        clr   = c;
        we    = w;
        waddr = wa;
        din   = d;
        re    = rd;
        raddr = ra;
        if (!r_n) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 4'h0, 4'h0, 0, 4'h0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) applyStimulus(1, 0, 0, 4'h0, 4'h0, 1, 4'(a));
    endtask

    task automatic check_inst(input int k, input logic [3:0] dout, input logic rvalid,
                              input logic busy, input logic werr);
        string      tag;
        logic [3:0] exp_rd;
        bit         empty;
        tag = (k == 0) ? "d16" : "d10";
        checkOutput({tag, " busy"}, 32'(busy), 32'(sweep_pos[k] >= 0));
        checkOutput({tag, " werr"}, 32'(werr), 32'(ref_werr[k]));
        checkOutput({tag, " rvalid"}, 32'(rvalid), 32'(ref_rvalid[k]));
        if (rvalid === 1'b1) begin
            empty = (k == 0) ? (expq_a.size() == 0) : (expq_b.size() == 0);
            n_vec++;
            if (empty) begin
                n_miss++;
                $display("[TB] FAIL %s rdq: got read data %0h, expected no read at %0t", tag, dout, $time);
            end else begin
                n_vec--;
                exp_rd = (k == 0) ? expq_a.pop_front() : expq_b.pop_front();
                checkOutput({tag, " dout"}, 32'(dout), 32'(exp_rd));
                ref_dout[k] = exp_rd;
            end
        end else begin
            checkOutput({tag, " dout_hold"}, 32'(dout), 32'(ref_dout[k]));
        end
    endtask

    bit mon_en = 1'b0;

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            check_inst(0, dout_a, rvalid_a, busy_a, werr_a);
            check_inst(1, dout_b, rvalid_b, busy_b, werr_b);
        end
    end

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) ref_mem[k][a] = 4'h0;
        rst_n = 1'b0; clr = 1'b0; we = 1'b0; waddr = 4'h0;
        din   = 4'h0; re  = 1'b0; raddr = 4'h0;
        model_reset();
        mon_en = 1'b1;

        // Reset with writes and clr requests applied, but no reads. The
        // array is not yet initialised, so reads would return unknown data.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 0, 4'h0);

        // Power-up sweep: 16 cycles for d16, 10 cycles for d10. Then read every word.
        idle(20);
        read_all();
        idle(1);

        // Write, read back, then check that dout holds.
        applyStimulus(1, 0, 1, 4'd3, 4'hA, 0, 4'h0);
        applyStimulus(1, 0, 0, 4'h0, 4'h0, 1, 4'd3);
        idle(2);

        // Same-edge read and write to one address returns the old word.
        applyStimulus(1, 0, 1, 4'd5, 4'h2, 0, 4'h0);
        applyStimulus(1, 0, 1, 4'd5, 4'h7, 1, 4'd5);
        applyStimulus(1, 0, 0, 4'h0, 4'h0, 1, 4'd5);
        idle(1);

        // Fill with F, clear, attempt a write mid-sweep, then read all.
        // The fill writes to addresses 10-15 also exercise the out-of-range
        // path on d10.
        for (int a = 0; a < 16; a++) applyStimulus(1, 0, 1, 4'(a), 4'hF, 0, 4'h0);
        applyStimulus(1, 1, 0, 4'h0, 4'h0, 0, 4'h0);
        idle(3);
        applyStimulus(1, 0, 1, 4'd9, 4'h3, 1, 4'd12);
        idle(16);
        read_all();

        // Reset in the middle of a sweep, with random inputs held during reset.
        applyStimulus(1, 1, 0, 4'h0, 4'h0, 0, 4'h0);
        idle(7);
        for (int i = 0; i < 2; i++)
            applyStimulus(0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                          1'($urandom), 4'($urandom));
        idle(18);

        // Randomised traffic, with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 29) == 0),
                          1'($urandom), 4'($urandom), 4'($urandom),
                          1'($urandom), 4'($urandom));
        end
        idle(3);

        checkOutput("d16 rdq_drained", 32'(expq_a.size()), 32'd0);
        checkOutput("d10 rdq_drained", 32'(expq_b.size()), 32'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
